// File: rtl/rv_exec_mem_ctrl.sv
// Execute/memory slice of a single-cycle RV32I core: main and ALU decoders, 32-bit ALU
// and a word-addressed data RAM with an asynchronous read port and an async clear.
module rv_exec_mem_ctrl #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic [31:0] src_a,
    input  logic [31:0] rd2,
    input  logic [31:0] imm_ext,
    output logic        pc_src,
    output logic        result_src,
    output logic        mem_write,
    output logic        alu_src,
    output logic [1:0]  imm_src,
    output logic        reg_write,
    output logic [2:0]  alu_control,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic [31:0] read_data,
    output logic [31:0] result
);
    localparam int AW = $clog2(MEM_WORDS);

    typedef struct packed {
        logic       reg_write;
        logic [1:0] imm_src;
        logic       alu_src;
        logic       mem_write;
        logic       result_src;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    ctrl_t       ctrl;
    logic [31:0] src_b;
    logic [AW-1:0] index;
    logic [31:0] mem [MEM_WORDS];

    always_comb begin
        ctrl = '0;
        case (op)
            7'b0000011: ctrl = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00}; // lw
            7'b0100011: ctrl = '{1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00}; // sw
            7'b0110011: ctrl = '{1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10}; // R-type
            7'b1100011: ctrl = '{1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01}; // beq
            7'b0010011: ctrl = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10}; // I-ALU
            default:    ctrl = '0;
        endcase
    end

    always_comb begin
        alu_control = 3'b000;
        case (ctrl.alu_op)
            2'b01: alu_control = 3'b001;
            2'b10: begin
                case (funct3)
                    // Only R-type honours funct7_5; for I-ALU that bit is immediate data
                    3'b000:  alu_control = (op[5] & funct7_5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    assign src_b = ctrl.alu_src ? imm_ext : rd2;

    always_comb begin
        alu_result = '0;
        case (alu_control)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = src_a - src_b;
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b101:  alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
            default: alu_result = '0;
        endcase
    end

    assign zero = (alu_result == 32'd0);

    // Upper address bits are dropped, so the RAM aliases every MEM_WORDS*4 bytes
    assign index = alu_result[AW+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
        end else if (ctrl.mem_write) begin
            mem[index] <= rd2;
        end
    end

    assign read_data  = mem[index];
    assign result     = ctrl.result_src ? read_data : alu_result;
    assign pc_src     = ctrl.branch & zero;
    assign result_src = ctrl.result_src;
    assign mem_write  = ctrl.mem_write;
    assign alu_src    = ctrl.alu_src;
    assign imm_src    = ctrl.imm_src;
    assign reg_write  = ctrl.reg_write;
endmodule

// File: tb/tb_rv_exec_mem_ctrl.sv
// Bench for rv_exec_mem_ctrl: directed scenarios plus randomized instructions checked
// against an instruction-level model with its own word-array memory.
module tb_rv_exec_mem_ctrl;
    localparam int MEM_WORDS = 64;
    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_BEQ = 7'b1100011, OP_I = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] src_a, rd2, imm_ext;
    logic        pc_src, result_src, mem_write, alu_src, reg_write, zero;
    logic [1:0]  imm_src;
    logic [2:0]  alu_control;
    logic [31:0] alu_result, read_data, result;

    int tests = 0;
    int fails = 0;
    logic [31:0] mdl [MEM_WORDS];

    rv_exec_mem_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .src_a(src_a), .rd2(rd2), .imm_ext(imm_ext), .pc_src(pc_src),
        .result_src(result_src), .mem_write(mem_write), .alu_src(alu_src),
        .imm_src(imm_src), .reg_write(reg_write), .alu_control(alu_control),
        .alu_result(alu_result), .zero(zero), .read_data(read_data), .result(result)
    );

    always #5 clk = ~clk;

    // Bundle order: pc_src,result_src,mem_write,alu_src,imm_src,reg_write,alu_control,alu_result,zero,read_data,result
    function automatic logic [106:0] model(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                           input logic [31:0] a, input logic [31:0] r2,
                                           input logic [31:0] imm);
        bit is_ld = (o == OP_LW), is_st = (o == OP_SW), is_r = (o == OP_R);
        bit is_br = (o == OP_BEQ), is_i = (o == OP_I);
        logic [31:0] b, res, rdv;
        logic [2:0] code;
        b = (is_ld || is_st || is_i) ? imm : r2;
        if (is_br) begin res = a - b; code = 3'b001; end
        else if (is_r || is_i) begin
            case (f3)
                3'b000: if (is_r && f7) begin res = a - b; code = 3'b001; end
                        else begin res = a + b; code = 3'b000; end
                3'b010: begin res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; code = 3'b101; end
                3'b110: begin res = a | b; code = 3'b011; end
                3'b111: begin res = a & b; code = 3'b010; end
                default: begin res = a + b; code = 3'b000; end
            endcase
        end else begin res = a + b; code = 3'b000; end
        rdv = mdl[(res / 4) % MEM_WORDS];
        return {is_br && res == 0, is_ld, is_st, is_ld || is_st || is_i,
                is_st ? 2'b01 : (is_br ? 2'b10 : 2'b00), is_ld || is_r || is_i,
                code, res, res == 0, rdv, is_ld ? rdv : res};
    endfunction

    function automatic logic [106:0] observed();
        return {pc_src, result_src, mem_write, alu_src, imm_src, reg_write, alu_control,
                alu_result, zero, read_data, result};
    endfunction

    task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] r2, input logic [31:0] imm);
        op = o; funct3 = f3; funct7_5 = f7; src_a = a; rd2 = r2; imm_ext = imm;
        #1;
    endtask

    // Clock edge that also commits an expected store into the model
    task automatic tick();
        logic st;
        st = (op == OP_SW) && rst_n;
        @(posedge clk);
        if (st) mdl[((src_a + imm_ext) / 4) % MEM_WORDS] = rd2;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < MEM_WORDS; i++) mdl[i] = '0;
        rst_n = 1'b0;
        drive(OP_LW, 3'b010, 1'b0, 32'h0, 32'h0, 32'h0);
        tests++;
        if (observed() !== model(OP_LW, 3'b010, 1'b0, 32'h0, 32'h0, 32'h0)) begin
            fails++; $display("FAIL reset_lw0 got %h exp %h", observed(), model(OP_LW, 3'b010, 1'b0, 0, 0, 0));
        end
        drive(OP_LW, 3'b010, 1'b0, 32'h4, 32'h0, 32'hF8);
        tests++;
        if (read_data !== 32'h0 || result !== 32'h0) begin
            fails++; $display("FAIL reset_rd got %h/%h exp 0", read_data, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rtype();
        @(negedge clk);
        drive(OP_R, 3'b000, 1'b1, 32'd5, 32'd7, 32'h123);
        tests++;
        if (alu_control !== 3'b001 || alu_result !== 32'hFFFFFFFE || reg_write !== 1'b1 ||
            result_src !== 1'b0 || result !== 32'hFFFFFFFE) begin
            fails++; $display("FAIL rtype_sub got ctl=%b res=%h rw=%b rs=%b exp 001 fffffffe 1 0",
                              alu_control, alu_result, reg_write, result_src);
        end
        drive(OP_R, 3'b010, 1'b0, -32'sd3, 32'd2, 32'h0);
        tests++;
        if (alu_result !== 32'd1 || alu_control !== 3'b101) begin
            fails++; $display("FAIL slt got %h/%b exp 1/101", alu_result, alu_control);
        end
        drive(OP_R, 3'b110, 1'b0, 32'hF0, 32'h0F, 32'h0);
        tests++;
        if (alu_result !== 32'hFF || alu_control !== 3'b011) begin
            fails++; $display("FAIL or got %h/%b exp ff/011", alu_result, alu_control);
        end
        drive(OP_R, 3'b111, 1'b0, 32'hF0, 32'h0F, 32'h0);
        tests++;
        if (alu_result !== 32'h0 || zero !== 1'b1 || alu_control !== 3'b010) begin
            fails++; $display("FAIL and got %h z=%b ctl=%b exp 0 1 010", alu_result, zero, alu_control);
        end
        drive(OP_I, 3'b000, 1'b1, 32'd5, 32'd99, 32'd7);
        tests++;
        if (alu_result !== 32'd12 || alu_src !== 1'b1 || alu_control !== 3'b000) begin
            fails++; $display("FAIL addi_f7 got %h src=%b ctl=%b exp c 1 000", alu_result, alu_src, alu_control);
        end
    endtask

    task automatic test_sw_lw();
        @(negedge clk);
        drive(OP_SW, 3'b010, 1'b0, 32'h100, 32'hDEADBEEF, 32'd8);
        tests++;
        if (mem_write !== 1'b1 || imm_src !== 2'b01 || read_data !== 32'h0 || reg_write !== 1'b0) begin
            fails++; $display("FAIL sw_ctrl got mw=%b is=%b rd=%h rw=%b exp 1 01 0 0",
                              mem_write, imm_src, read_data, reg_write);
        end
        tick();
        drive(OP_LW, 3'b010, 1'b0, 32'h100, 32'h0, 32'd8);
        tests++;
        if (result !== 32'hDEADBEEF || imm_src !== 2'b00 || result_src !== 1'b1) begin
            fails++; $display("FAIL lw_back got %h is=%b rs=%b exp deadbeef 00 1", result, imm_src, result_src);
        end
        // Overwrite: old data stays visible until the edge
        @(negedge clk);
        drive(OP_SW, 3'b010, 1'b0, 32'h100, 32'h12345678, 32'd8);
        tests++;
        if (read_data !== 32'hDEADBEEF) begin
            fails++; $display("FAIL same_cycle_old got %h exp deadbeef", read_data);
        end
        tick();
        tests++;
        if (read_data !== 32'h12345678) begin
            fails++; $display("FAIL after_edge got %h exp 12345678", read_data);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        drive(OP_SW, 3'b010, 1'b0, 32'h0, 32'hCAFEF00D, 32'h0);
        tick();
        drive(OP_LW, 3'b010, 1'b0, 32'h100, 32'h0, 32'h3);
        tests++;
        if (result !== 32'hCAFEF00D) begin
            fails++; $display("FAIL addr_wrap got %h exp cafef00d", result);
        end
    endtask

    task automatic test_beq();
        @(negedge clk);
        drive(OP_BEQ, 3'b000, 1'b0, 32'd9, 32'd9, 32'h40);
        tests++;
        if (zero !== 1'b1 || pc_src !== 1'b1 || imm_src !== 2'b10 || reg_write !== 1'b0) begin
            fails++; $display("FAIL beq_taken got z=%b pc=%b is=%b exp 1 1 10", zero, pc_src, imm_src);
        end
        drive(OP_BEQ, 3'b000, 1'b0, 32'd9, 32'd8, 32'h40);
        tests++;
        if (pc_src !== 1'b0 || zero !== 1'b0) begin
            fails++; $display("FAIL beq_not got pc=%b z=%b exp 0 0", pc_src, zero);
        end
        drive(7'b1101111, 3'b111, 1'b1, 32'd0, 32'd0, 32'h0);
        tests++;
        if ({pc_src, result_src, mem_write, alu_src, imm_src, reg_write, alu_control} !== 10'b0) begin
            fails++; $display("FAIL unknown_op got %b exp 0",
                              {pc_src, result_src, mem_write, alu_src, imm_src, reg_write, alu_control});
        end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) mdl[i] = '0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            drive(OP_LW, 3'b010, 1'b0, i * 4, 32'h0, 32'h0);
            tests++;
            if (read_data !== 32'h0) begin
                fails++; $display("FAIL midrun_clear[%0d] got %h exp 0", i, read_data);
            end
        end
        drive(OP_SW, 3'b010, 1'b0, 32'h10, 32'h5555AAAA, 32'h0);
        tick();
        tests++;
        if (read_data !== 32'h0) begin
            fails++; $display("FAIL write_blocked got %h exp 0", read_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tick();
        tests++;
        if (read_data !== 32'h5555AAAA) begin
            fails++; $display("FAIL write_resume got %h exp 5555aaaa", read_data);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [6];
        logic [6:0] o;
        logic [31:0] a, b, imm;
        ops = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_I, 7'h0};
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            o = ops[$urandom_range(0, 5)];
            if (o == 7'h0) o = 7'($urandom);
            a = (n % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            b = (n % 4 == 0) ? a : $urandom;
            imm = (o == OP_LW || o == OP_SW) ? 32'($urandom_range(0, 1023)) : $urandom;
            drive(o, 3'($urandom), 1'($urandom), a, b, imm);
            tests++;
            if (observed() !== model(op, funct3, funct7_5, src_a, rd2, imm_ext)) begin
                fails++; $display("FAIL random[%0d] op=%b got %h exp %h", n, op, observed(),
                                  model(op, funct3, funct7_5, src_a, rd2, imm_ext));
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        op = '0; funct3 = '0; funct7_5 = 1'b0; src_a = '0; rd2 = '0; imm_ext = '0;
        test_reset();
        test_rtype();
        test_sw_lw();
        test_wrap();
        test_beq();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
